// File: rtl/grain_pkg.sv
// Shared definitions for the Grain keystream consumer: FSM state encoding
// and default widths/lengths for the seed, warm-up and byte paths.
package grain_pkg;

    localparam int GRAIN_SEED_W = 80;
    localparam int GRAIN_WARMUP = 160;
    localparam int GRAIN_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WARMUP  = 3'd2,
        ST_READY   = 3'd3,
        ST_COLLECT = 3'd4,
        ST_OUT     = 3'd5
    } grain_state_e;

endpackage

// File: rtl/grain_byte_collector.sv
// Gathers DATA_W consecutive keystream bits into a byte, first bit ending up
// in the MSB. The bit counter saturates at DATA_W; done flags the cycle in
// which the final bit is being sampled so the owner can leave its collect
// phase on that same edge.
module grain_byte_collector
    import grain_pkg::*;
#(
    parameter int DATA_W = GRAIN_BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift,
    input  logic              bit_in,
    output logic [DATA_W-1:0] ks_byte,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [CNT_W-1:0] count;

    // Shift keystream bits in at the LSB, count them, hold once full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ks_byte <= '0;
            count   <= '0;
        end else if (clear) begin
            ks_byte <= '0;
            count   <= '0;
        end else if (shift && (count != CNT_W'(DATA_W))) begin
            ks_byte <= {ks_byte[DATA_W-2:0], bit_in};
            count   <= count + 1'b1;
        end
    end

    assign done = shift && (count == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/grain_stream_xor.sv
// Sequencer and byte cipher on top of a serial Grain keystream generator.
// Loads the seed, discards WARMUP_CYCLES keystream bits, then XORs each
// plaintext byte MSB-first with the next DATA_W keystream bits.
// Optional build macro GRAIN_KS_TAP_EN adds ks_byte and warm_done taps.
//
// Handshakes: a byte moves on a rising edge where valid and ready are both
// high. ready never depends on valid combinationally; once ct_valid is
// raised it stays high with ct_data unchanged until the edge that sees
// ct_ready high.
module grain_stream_xor
    import grain_pkg::*;
#(
    parameter int SEED_W        = GRAIN_SEED_W,
    parameter int DATA_W        = GRAIN_BYTE_W,
    parameter int WARMUP_CYCLES = GRAIN_WARMUP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEED_W-1:0] seed,
    output logic              busy,
    output logic [SEED_W-1:0] ks_seed,
    output logic              ks_load,
    output logic              ks_shift_en,
    input  logic              ks_bit,
    input  logic              pt_valid,
    input  logic [DATA_W-1:0] pt_data,
    output logic              pt_ready,
    output logic              ct_valid,
    output logic [DATA_W-1:0] ct_data,
    input  logic              ct_ready,
`ifdef GRAIN_KS_TAP_EN
    output logic [DATA_W-1:0] ks_byte,
    output logic              warm_done,
`endif
    output logic [2:0]        fsm_state
);

    localparam int WCNT_W = $clog2(WARMUP_CYCLES + 1);

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_LOAD    = ST_LOAD;
    localparam logic [2:0] S_WARMUP  = ST_WARMUP;
    localparam logic [2:0] S_READY   = ST_READY;
    localparam logic [2:0] S_COLLECT = ST_COLLECT;
    localparam logic [2:0] S_OUT     = ST_OUT;

    logic [2:0]        state;
    logic [WCNT_W-1:0] warm_cnt;
    logic [DATA_W-1:0] pt_reg;
    logic [DATA_W-1:0] ks_collected;
    logic              col_done;
    logic              warm_last;
    logic              start_ok;
    logic              pt_take;

    // start is only honoured when nothing is in flight; it beats pt_valid.
    assign start_ok  = start && ((state == S_IDLE) || (state == S_READY));
    assign pt_take   = (state == S_READY) && pt_valid && !start;
    assign warm_last = (state == S_WARMUP) && (warm_cnt == WCNT_W'(WARMUP_CYCLES - 1));

    // Main sequencer: rekey, warm-up, then one byte at a time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start) state <= S_LOAD;
                S_LOAD:    state <= S_WARMUP;
                S_WARMUP:  if (warm_last) state <= S_READY;
                S_READY: begin
                    if (start)         state <= S_LOAD;
                    else if (pt_valid) state <= S_COLLECT;
                end
                S_COLLECT: if (col_done) state <= S_OUT;
                S_OUT:     if (ct_ready) state <= S_READY;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Seed register feeding the generator's parallel load port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ks_seed <= '0;
        end else if (start_ok) begin
            ks_seed <= seed;
        end
    end

    // Warm-up bit counter, cleared in LOAD, saturating at its terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            warm_cnt <= '0;
        end else if (state == S_LOAD) begin
            warm_cnt <= '0;
        end else if ((state == S_WARMUP) && (warm_cnt != WCNT_W'(WARMUP_CYCLES))) begin
            warm_cnt <= warm_cnt + 1'b1;
        end
    end

    // Plaintext holding register, captured on the accepting edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pt_reg <= '0;
        end else if (pt_take) begin
            pt_reg <= pt_data;
        end
    end

    grain_byte_collector #(
        .DATA_W (DATA_W)
    ) u_collector (
        .clk     (clk),
        .rst     (rst),
        .clear   (pt_take),
        .shift   (state == S_COLLECT),
        .bit_in  (ks_bit),
        .ks_byte (ks_collected),
        .done    (col_done)
    );

    // Output decode from the registered state; ct_data is masked outside OUT.
    always_comb begin
        busy        = (state == S_LOAD) || (state == S_WARMUP) ||
                      (state == S_COLLECT) || (state == S_OUT);
        ks_load     = (state == S_LOAD);
        ks_shift_en = (state == S_WARMUP) || (state == S_COLLECT);
        pt_ready    = (state == S_READY);
        ct_valid    = (state == S_OUT);
        ct_data     = (state == S_OUT) ? (pt_reg ^ ks_collected) : '0;
    end

    assign fsm_state = state;

`ifdef GRAIN_KS_TAP_EN
    assign ks_byte = (state == S_OUT) ? ks_collected : '0;

    // One-cycle marker in the first READY cycle after warm-up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            warm_done <= 1'b0;
        end else begin
            warm_done <= warm_last;
        end
    end
`endif

endmodule

// File: tb/tb_grain_stream_xor.sv
// Directed bench for grain_stream_xor. The keystream generator is replaced
// by a bench-side bit source: a shift counter reset by ks_load and advanced
// by ks_shift_en, indexing into a table of keystream bytes (MSB first).
module tb_grain_stream_xor;
    import grain_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [79:0] seed = '0;
    logic        busy;
    logic [79:0] ks_seed;
    logic        ks_load;
    logic        ks_shift_en;
    logic        ks_bit;
    logic        pt_valid = 1'b0;
    logic [7:0]  pt_data = '0;
    logic        pt_ready;
    logic        ct_valid;
    logic [7:0]  ct_data;
    logic        ct_ready = 1'b1;
    logic [2:0]  fsm_state;

    int n_cmp  = 0;
    int n_fail = 0;
    int byte_n = 0;

    logic [15:0] shift_cnt = '0;
    logic [15:0] ks_idx;
    logic [7:0]  ks_bytes [0:31];
    logic [7:0]  exp_q [$];

    localparam logic [79:0] SEED_MAIN = 80'h123456789ABCDEF01234;
    localparam logic [79:0] SEED_B    = 80'hFEDCBA98765432100F0F;
    localparam logic [79:0] SEED_C    = 80'h0F1E2D3C4B5A69788796;

    grain_stream_xor dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .seed        (seed),
        .busy        (busy),
        .ks_seed     (ks_seed),
        .ks_load     (ks_load),
        .ks_shift_en (ks_shift_en),
        .ks_bit      (ks_bit),
        .pt_valid    (pt_valid),
        .pt_data     (pt_data),
        .pt_ready    (pt_ready),
        .ct_valid    (ct_valid),
        .ct_data     (ct_data),
        .ct_ready    (ct_ready),
        .fsm_state   (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Bench keystream source: position advances on each requested shift.
    always @(posedge clk) begin
        if (ks_load)          shift_cnt <= '0;
        else if (ks_shift_en) shift_cnt <= shift_cnt + 16'd1;
    end

    always_comb begin
        ks_idx = '0;
        ks_bit = 1'b0;
        if (shift_cnt < 16'd160) begin
            ks_bit = shift_cnt[0];
        end else begin
            ks_idx = shift_cnt - 16'd160;
            ks_bit = ks_bytes[ks_idx[7:3]][3'd7 - ks_idx[2:0]];
        end
    end

    // Driver: rekey from IDLE/READY and wait for pt_ready (bounded).
    task automatic drive_rekey(input logic [79:0] s);
        int c;
        @(negedge clk);
        start = 1'b1;
        seed  = s;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!pt_ready && c < 300) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (pt_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rekey_ready_timeout: pt_ready=%b expected 1", pt_ready);
        end
        byte_n = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, ks_load, ks_shift_en, pt_ready, ct_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, ks_load, ks_shift_en, pt_ready, ct_valid});
        end
        n_cmp++;
        if (ks_seed !== 80'h0 || ct_data !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_data: ks_seed=%h ct_data=%h expected 0", ks_seed, ct_data);
        end
        n_cmp++;
        if (fsm_state !== 3'(ST_IDLE)) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", fsm_state, ST_IDLE);
        end
        // Release, start a key load, then reset again at warm-up cycle 50.
        rst = 1'b1;
        @(negedge clk);
        start = 1'b1;
        seed  = SEED_B;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        n_cmp++;
        if (ks_shift_en !== 1'b1 || busy !== 1'b1 || ks_seed !== SEED_B) begin
            n_fail++;
            $display("FAIL warmup_mid: shift_en=%b busy=%b ks_seed=%h expected 1 1 %h", ks_shift_en, busy, ks_seed, SEED_B);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, ks_load, ks_shift_en, pt_ready, ct_valid} !== 5'b0 || ks_seed !== 80'h0 || ct_data !== 8'h0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: ctrl=%b ks_seed=%h ct_data=%h expected all 0", {busy, ks_load, ks_shift_en, pt_ready, ct_valid}, ks_seed, ct_data);
        end
        n_cmp++;
        if (fsm_state !== 3'(ST_IDLE)) begin
            n_fail++;
            $display("FAIL async_reset_state: got %0d expected %0d", fsm_state, ST_IDLE);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (fsm_state !== 3'(ST_IDLE) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: state=%0d busy=%b expected %0d 0", fsm_state, busy, ST_IDLE);
        end
    endtask

    task automatic test_rekey_timing();
        int first_ready = -1;
        int first_shift = -1;
        int last_shift  = -1;
        int load_cnt    = 0;
        int shift_tot   = 0;
        int overlap     = 0;
        @(negedge clk);
        start = 1'b1;
        seed  = SEED_MAIN;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                seed  = '0;
                n_cmp++;
                if (ks_load !== 1'b1 || ks_seed !== SEED_MAIN) begin
                    n_fail++;
                    $display("FAIL load_cycle1: ks_load=%b ks_seed=%h expected 1 %h", ks_load, ks_seed, SEED_MAIN);
                end
            end
            if (ks_load) load_cnt++;
            if (ks_shift_en) begin
                shift_tot++;
                if (first_shift < 0) first_shift = c;
                last_shift = c;
            end
            if (ks_load && ks_shift_en) overlap++;
            if (pt_ready) begin
                first_ready = c;
                break;
            end
        end
        n_cmp++;
        if (load_cnt !== 1 || overlap !== 0) begin
            n_fail++;
            $display("FAIL load_pulse: loads=%0d overlap=%0d expected 1 0", load_cnt, overlap);
        end
        n_cmp++;
        if (shift_tot !== 160 || first_shift !== 2 || last_shift !== 161) begin
            n_fail++;
            $display("FAIL warmup_shifts: count=%0d first=%0d last=%0d expected 160 2 161", shift_tot, first_shift, last_shift);
        end
        n_cmp++;
        if (first_ready !== 162) begin
            n_fail++;
            $display("FAIL ready_cycle: got %0d expected 162", first_ready);
        end
        n_cmp++;
        if (ks_seed !== SEED_MAIN || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_seed_busy: ks_seed=%h busy=%b expected %h 0", ks_seed, busy, SEED_MAIN);
        end
        byte_n = 0;
    endtask

    task automatic test_byte_xor();
        logic [7:0] pts  [2] = '{8'hA5, 8'hA5};
        logic [7:0] kss  [2] = '{8'hFF, 8'hA1};
        logic [7:0] exps [2] = '{8'h5A, 8'h04};
        for (int i = 0; i < 2; i++) begin
            int ct_cyc = -1;
            int shifts = 0;
            logic [7:0] got = '0;
            ks_bytes[byte_n] = kss[i];
            byte_n++;
            ct_ready = 1'b1;
            pt_valid = 1'b1;
            pt_data  = pts[i];
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                if (c == 1) pt_valid = 1'b0;
                if (ks_shift_en) shifts++;
                if (ct_valid) begin
                    ct_cyc = c;
                    got    = ct_data;
                    break;
                end
            end
            n_cmp++;
            if (ct_cyc !== 9 || shifts !== 8) begin
                n_fail++;
                $display("FAIL xor_timing[%0d]: ct_cycle=%0d shifts=%0d expected 9 8", i, ct_cyc, shifts);
            end
            n_cmp++;
            if (got !== exps[i]) begin
                n_fail++;
                $display("FAIL xor_data[%0d]: got %h expected %h", i, got, exps[i]);
            end
            @(negedge clk);
            n_cmp++;
            if (pt_ready !== 1'b1 || ct_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL xor_return[%0d]: pt_ready=%b ct_valid=%b expected 1 0", i, pt_ready, ct_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int ct_cyc = -1;
        int bad    = 0;
        ks_bytes[byte_n] = 8'hC3;
        byte_n++;
        ct_ready = 1'b0;
        pt_valid = 1'b1;
        pt_data  = 8'h3C;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) pt_valid = 1'b0;
            if (ct_valid) begin
                ct_cyc = c;
                break;
            end
        end
        n_cmp++;
        if (ct_cyc !== 9 || ct_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL bp_first: ct_cycle=%0d ct_data=%h expected 9 ff", ct_cyc, ct_data);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ct_valid !== 1'b1 || ct_data !== 8'hFF || pt_ready !== 1'b0 || ks_shift_en !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d bad cycles expected 0", bad);
        end
        ct_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ct_valid !== 1'b0 || pt_ready !== 1'b1 || fsm_state !== 3'(ST_READY)) begin
            n_fail++;
            $display("FAIL bp_release: ct_valid=%b pt_ready=%b state=%0d expected 0 1 %0d", ct_valid, pt_ready, fsm_state, ST_READY);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ct_valid !== 1'b0 || fsm_state !== 3'(ST_READY)) begin
            n_fail++;
            $display("FAIL bp_single: ct_valid=%b state=%0d expected 0 %0d", ct_valid, fsm_state, ST_READY);
        end
    endtask

    task automatic test_ignored_start();
        int ct_cyc = -1;
        int shifts = 0;
        int loads  = 0;
        logic [7:0] got = '0;
        ks_bytes[byte_n] = 8'h96;
        byte_n++;
        pt_valid = 1'b1;
        pt_data  = 8'h0F;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) pt_valid = 1'b0;
            if (c == 3) begin
                start = 1'b1;
                seed  = SEED_C;
            end
            if (c == 4) start = 1'b0;
            if (ks_shift_en) shifts++;
            if (ks_load) loads++;
            if (ct_valid) begin
                ct_cyc = c;
                got    = ct_data;
                break;
            end
        end
        n_cmp++;
        if (ct_cyc !== 9 || shifts !== 8 || loads !== 0) begin
            n_fail++;
            $display("FAIL ign_timing: ct_cycle=%0d shifts=%0d loads=%0d expected 9 8 0", ct_cyc, shifts, loads);
        end
        n_cmp++;
        if (got !== 8'h99 || ks_seed !== SEED_MAIN) begin
            n_fail++;
            $display("FAIL ign_data: ct_data=%h ks_seed=%h expected 99 %h", got, ks_seed, SEED_MAIN);
        end
        @(negedge clk);
        n_cmp++;
        if (fsm_state !== 3'(ST_READY)) begin
            n_fail++;
            $display("FAIL ign_not_queued: state=%0d expected %0d", fsm_state, ST_READY);
        end
    endtask

    task automatic test_rekey_collision();
        int first_ready = -1;
        int ct_seen     = 0;
        int ct_cyc      = -1;
        logic [7:0] got = '0;
        start    = 1'b1;
        seed     = SEED_C;
        pt_valid = 1'b1;
        pt_data  = 8'h77;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start    = 1'b0;
                pt_valid = 1'b0;
                n_cmp++;
                if (ks_load !== 1'b1 || fsm_state !== 3'(ST_LOAD) || ks_seed !== SEED_C) begin
                    n_fail++;
                    $display("FAIL coll_load: ks_load=%b state=%0d ks_seed=%h expected 1 %0d %h", ks_load, fsm_state, ks_seed, ST_LOAD, SEED_C);
                end
            end
            if (ct_valid) ct_seen++;
            if (pt_ready) begin
                first_ready = c;
                break;
            end
        end
        n_cmp++;
        if (first_ready !== 162 || ct_seen !== 0) begin
            n_fail++;
            $display("FAIL coll_ready: ready_cycle=%0d ct_seen=%0d expected 162 0", first_ready, ct_seen);
        end
        // The dropped byte must not resurface; the next one uses fresh keystream.
        byte_n = 0;
        ks_bytes[byte_n] = 8'h5C;
        byte_n++;
        pt_valid = 1'b1;
        pt_data  = 8'h33;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) pt_valid = 1'b0;
            if (ct_valid) begin
                ct_cyc = c;
                got    = ct_data;
                break;
            end
        end
        n_cmp++;
        if (ct_cyc !== 9 || got !== 8'h6F) begin
            n_fail++;
            $display("FAIL coll_next_byte: ct_cycle=%0d ct_data=%h expected 9 6f", ct_cyc, got);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] pts [16];
        logic [7:0] exp_v;
        int sent    = 0;
        int got_n   = 0;
        int last_ct = -1;
        int gap_bad = 0;
        for (int i = 0; i < 16; i++) begin
            pts[i] = 8'(i * 37 + 5);
            ks_bytes[byte_n + i] = 8'(i * 91 + 8'h3C);
        end
        ct_ready = 1'b1;
        for (int c = 0; c < 400 && got_n < 16; c++) begin
            @(negedge clk);
            if (ct_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_unexpected: ct_data=%h with empty expected queue", ct_data);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (ct_data !== exp_v) begin
                        n_fail++;
                        $display("FAIL b2b_data[%0d]: got %h expected %h", got_n, ct_data, exp_v);
                    end
                end
                if (last_ct >= 0 && (c - last_ct) != 10) gap_bad++;
                last_ct = c;
                got_n++;
            end
            if (pt_ready && sent < 16) begin
                pt_valid = 1'b1;
                pt_data  = pts[sent];
                exp_q.push_back(pts[sent] ^ ks_bytes[byte_n + sent]);
                sent++;
            end else begin
                pt_valid = 1'b0;
            end
        end
        pt_valid = 1'b0;
        n_cmp++;
        if (got_n !== 16 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d bytes, %0d left expected 16 0", got_n, exp_q.size());
        end
        n_cmp++;
        if (gap_bad !== 0) begin
            n_fail++;
            $display("FAIL b2b_rate: %0d gaps not 10 cycles expected 0", gap_bad);
        end
        byte_n += 16;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) ks_bytes[i] = 8'h00;
        test_reset();
        test_rekey_timing();
        test_byte_xor();
        test_backpressure();
        test_ignored_start();
        test_rekey_collision();
        test_back_to_back();
        drive_rekey(SEED_MAIN);
        n_cmp++;
        if (ks_seed !== SEED_MAIN || fsm_state !== 3'(ST_READY)) begin
            n_fail++;
            $display("FAIL final_rekey: ks_seed=%h state=%0d expected %h %0d", ks_seed, fsm_state, SEED_MAIN, ST_READY);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
